// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - uart_rx line/tick inputs and received-byte outputs
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 ena;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 bussy;

    modport master (
        output ena, rx,
        input  data, valid, frame_err, bussy
    );

    modport slave (
        input  ena, rx,
        output data, valid, frame_err, bussy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with start-glitch rejection and stop-bit check
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nx;
    logic [TW-1:0]        tcnt, tcnt_nx;
    logic [BW-1:0]        bitcnt, bitcnt_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [DATA_BITS-1:0] data_q, data_nx;
    logic                 valid_q, valid_nx;
    logic                 ferr_q, ferr_nx;
    logic                 bussy_q, bussy_nx;
    logic                 sync1, rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            tcnt    <= '0;
            bitcnt  <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            bussy_q <= 1'b0;
        end else begin
            sync1   <= bus.rx;
            rx_s    <= sync1;
            state   <= state_nx;
            tcnt    <= tcnt_nx;
            bitcnt  <= bitcnt_nx;
            shift   <= shift_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            ferr_q  <= ferr_nx;
            bussy_q <= bussy_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tcnt_nx   = tcnt;
        bitcnt_nx = bitcnt;
        shift_nx  = shift;
        data_nx   = data_q;
        valid_nx  = 1'b0;
        ferr_nx   = 1'b0;
        if (bus.ena) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx = START;
                        tcnt_nx  = '0;
                    end
                end
                START: begin
                    // Confirm the start bit at its centre; a high line here was a glitch.
                    if (tcnt == T_MID) begin
                        tcnt_nx   = '0;
                        bitcnt_nx = '0;
                        state_nx  = rx_s ? IDLE : DATA;
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
                DATA: begin
                    if (tcnt == T_END) begin
                        shift_nx  = {rx_s, shift[DATA_BITS-1:1]};
                        tcnt_nx   = '0;
                        bitcnt_nx = bitcnt + BW'(1);
                        if (bitcnt == B_LAST) state_nx = STOP;
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
                    if (tcnt == T_END) begin
                        state_nx = IDLE;
                        tcnt_nx  = '0;
                        if (rx_s) begin
                            data_nx  = shift;
                            valid_nx = 1'b1;
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end else begin
                        tcnt_nx = tcnt + TW'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        bussy_nx = (state_nx != IDLE);
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.bussy     = bussy_q;
endmodule
